adjacency_map_mq: RTL and testbench

Multi-port successor to the single-client adjacency map: stores a directed graph built from a stream of decoded `src -> dst` edges and serves neighbour-list queries from `NUM_PORTS` independent clients. Per-node edges are held as linked lists, so edges may arrive in any order; they are no longer required to be grouped by source. A round-robin arbiter admits one query at a time. Replies stream on one shared ready/valid channel, tagged with the requesting port. The block sits between the input decoder and the path-counting/traversal engines.

---
 rtl/adjacency_map_mq.sv | 174 +++++++++++++++++
 tb/tb_adjacency_map_mq.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adjacency_map_mq.sv
// Directed-graph store built from an edge stream, served to NUM_PORTS round-robin query clients.
// Optional statistics counters are enabled by defining ADJ_MAP_STATS_EN.
module adjacency_map_mq #(
  parameter int MAX_NODES      = 1024,
  parameter int MAX_EDGES      = 2048,
  parameter int NUM_PORTS      = 2,
  parameter int NODE_WIDTH     = $clog2(MAX_NODES),
  parameter int EDGE_PTR_WIDTH = $clog2(MAX_EDGES),
  parameter int PORT_WIDTH     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            decoding_done,
  input  logic                            edge_valid,
  input  logic [NODE_WIDTH-1:0]           src_node,
  input  logic [NODE_WIDTH-1:0]           dst_node,
  output logic                            edge_overflow,
  input  logic [NUM_PORTS-1:0]            query_valid,
  output logic [NUM_PORTS-1:0]            query_ready,
  input  logic [NUM_PORTS*NODE_WIDTH-1:0] query_data,
  output logic                            reply_valid,
  input  logic                            reply_ready,
  output logic [NODE_WIDTH-1:0]           reply_data,
  output logic [PORT_WIDTH-1:0]           reply_port,
  output logic                            reply_last,
  output logic                            reply_no_edges_found,
  output logic [EDGE_PTR_WIDTH:0]         stat_edge_count,
  output logic [NODE_WIDTH:0]             stat_node_count
);

  // state    | meaning
  // S_BUILD  | accepting edges, queries blocked
  // S_ARB    | round-robin grant of one query
  // S_LOOKUP | read head/tail of the queried node
  // S_REPLY  | stream the neighbour list, one beat per handshake
  typedef enum logic [1:0] {S_BUILD, S_ARB, S_LOOKUP, S_REPLY} state_t;

  state_t                    r_state;
  logic [EDGE_PTR_WIDTH:0]   r_wr_ptr;
  logic [MAX_NODES-1:0]      r_has_edges;
  logic [PORT_WIDTH-1:0]     r_last_grant;
  logic [NODE_WIDTH-1:0]     r_q_node;
  logic [PORT_WIDTH-1:0]     r_q_port;
  logic [EDGE_PTR_WIDTH-1:0] r_rd_ptr;
  logic [EDGE_PTR_WIDTH-1:0] r_tail_q;
  logic                      r_no_edges;
  logic                      r_overflow;

  logic [EDGE_PTR_WIDTH-1:0] r_node_head [MAX_NODES];
  logic [EDGE_PTR_WIDTH-1:0] r_node_tail [MAX_NODES];
  logic [NODE_WIDTH-1:0]     r_edge_dst  [MAX_EDGES];
  logic [EDGE_PTR_WIDTH-1:0] r_edge_next [MAX_EDGES];

  logic                      w_full;
  logic                      w_edge_in;
  logic                      w_edge_wr;
  logic [EDGE_PTR_WIDTH-1:0] w_wr_idx;
  logic                      w_src_has;
  logic [EDGE_PTR_WIDTH-1:0] w_src_tail;
  logic                      w_grant_found;
  logic [PORT_WIDTH-1:0]     w_grant_idx;
  logic [NODE_WIDTH-1:0]     w_q_node;
  logic                      w_reply_last;

  assign w_full     = (r_wr_ptr == (EDGE_PTR_WIDTH+1)'(MAX_EDGES));
  assign w_edge_in  = (r_state == S_BUILD) && edge_valid;
  assign w_edge_wr  = w_edge_in && !w_full;
  assign w_wr_idx   = r_wr_ptr[EDGE_PTR_WIDTH-1:0];
  assign w_src_has  = r_has_edges[src_node];
  assign w_src_tail = r_node_tail[src_node];

  // Search starts one past the last winner so every requester is served in turn.
  always_comb begin : arb
    logic [PORT_WIDTH:0]   v_k;
    logic [PORT_WIDTH-1:0] v_p;
    v_k           = '0;
    v_p           = '0;
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      v_k = {1'b0, r_last_grant} + (PORT_WIDTH+1)'(i);
      if (v_k >= (PORT_WIDTH+1)'(NUM_PORTS)) v_k = v_k - (PORT_WIDTH+1)'(NUM_PORTS);
      v_p = v_k[PORT_WIDTH-1:0];
      if (!w_grant_found && query_valid[v_p]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = v_p;
      end
    end
  end

  assign w_q_node     = query_data[w_grant_idx*NODE_WIDTH +: NODE_WIDTH];
  assign w_reply_last = r_no_edges || (r_rd_ptr == r_tail_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_BUILD;
      r_wr_ptr     <= '0;
      r_has_edges  <= '0;
      r_last_grant <= PORT_WIDTH'(NUM_PORTS - 1);
      r_q_node     <= '0;
      r_q_port     <= '0;
      r_rd_ptr     <= '0;
      r_tail_q     <= '0;
      r_no_edges   <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_edge_in && w_full) r_overflow <= 1'b1;
      case (r_state)
        S_BUILD: begin
          if (w_edge_wr) begin
            r_wr_ptr              <= r_wr_ptr + 1'b1;
            r_has_edges[src_node] <= 1'b1;
          end
          if (decoding_done) r_state <= S_ARB;
        end
        S_ARB: begin
          if (w_grant_found) begin
            r_q_node     <= w_q_node;
            r_q_port     <= w_grant_idx;
            r_last_grant <= w_grant_idx;
            r_state      <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          r_rd_ptr   <= r_node_head[r_q_node];
          r_tail_q   <= r_node_tail[r_q_node];
          r_no_edges <= !r_has_edges[r_q_node];
          r_state    <= S_REPLY;
        end
        S_REPLY: begin
          if (reply_ready) begin
            if (w_reply_last) r_state  <= S_ARB;
            else              r_rd_ptr <= r_edge_next[r_rd_ptr];
          end
        end
        default: r_state <= S_BUILD;
      endcase
    end
  end

  // Node and edge tables are plain RAM; the has_edges flops qualify their contents.
  always_ff @(posedge clk) begin
    if (w_edge_wr) begin
      r_edge_dst[w_wr_idx] <= dst_node;
      if (!w_src_has) r_node_head[src_node]   <= w_wr_idx;
      else            r_edge_next[w_src_tail] <= w_wr_idx;
      r_node_tail[src_node] <= w_wr_idx;
    end
  end

  assign query_ready          = (r_state == S_ARB && w_grant_found) ? (NUM_PORTS'(1) << w_grant_idx) : '0;
  assign reply_valid          = (r_state == S_REPLY);
  assign reply_data           = (r_state == S_REPLY && !r_no_edges) ? r_edge_dst[r_rd_ptr] : '0;
  assign reply_port           = r_q_port;
  assign reply_last           = (r_state == S_REPLY) && w_reply_last;
  assign reply_no_edges_found = (r_state == S_REPLY) && r_no_edges;
  assign edge_overflow        = r_overflow;

`ifdef ADJ_MAP_STATS_EN
  logic [NODE_WIDTH:0] r_node_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_node_count <= '0;
    else if (w_edge_wr && !w_src_has) r_node_count <= r_node_count + 1'b1;
  end

  assign stat_edge_count = r_wr_ptr;
  assign stat_node_count = r_node_count;
`else
  assign stat_edge_count = '0;
  assign stat_node_count = '0;
`endif

endmodule

// File: tb/tb_adjacency_map_mq.sv
// Scoreboard bench for adjacency_map_mq: random edges and queries against a queue-based graph model.
module tb_adjacency_map_mq;
  localparam int MN = 16;
  localparam int ME = 32;
  localparam int NP = 3;
  localparam int NW = $clog2(MN);
  localparam int EW = $clog2(ME);
  localparam int PW = (NP > 1) ? $clog2(NP) : 1;

  logic             clk = 0;
  logic             rst_n;
  logic             decoding_done, edge_valid;
  logic [NW-1:0]    src_node, dst_node;
  logic             edge_overflow;
  logic [NP-1:0]    query_valid, query_ready;
  logic [NP*NW-1:0] query_data;
  logic             reply_valid, reply_ready;
  logic [NW-1:0]    reply_data;
  logic [PW-1:0]    reply_port;
  logic             reply_last, reply_no_edges_found;
  logic [EW:0]      stat_edge_count;
  logic [NW:0]      stat_node_count;

  adjacency_map_mq #(.MAX_NODES(MN), .MAX_EDGES(ME), .NUM_PORTS(NP)) dut (
    .clk(clk), .rst_n(rst_n), .decoding_done(decoding_done), .edge_valid(edge_valid),
    .src_node(src_node), .dst_node(dst_node), .edge_overflow(edge_overflow),
    .query_valid(query_valid), .query_ready(query_ready), .query_data(query_data),
    .reply_valid(reply_valid), .reply_ready(reply_ready), .reply_data(reply_data),
    .reply_port(reply_port), .reply_last(reply_last),
    .reply_no_edges_found(reply_no_edges_found),
    .stat_edge_count(stat_edge_count), .stat_node_count(stat_node_count));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NW-1:0] d;
    logic [PW-1:0] p;
    logic          l;
    logic          n;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  // reference model: per-node neighbour queues in insertion order
  int adj[MN][$];
  int m_edges;
  bit m_ovf;
  int m_last;

  int rr_mode = 0;
  int pat_i = 0;
  bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int next_grant(input int last, input logic [NP-1:0] m);
    for (int i = 1; i <= NP; i++) begin
      int p;
      p = (last + i) % NP;
      if (m[p]) return p;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < MN; i++) adj[i].delete();
    m_edges = 0;
    m_ovf   = 0;
    m_last  = NP - 1;
  endtask

  task automatic push_expect(input int node, input int port);
    beat_t b;
    if (adj[node].size() == 0) begin
      b.d = '0; b.p = PW'(port); b.l = 1'b1; b.n = 1'b1;
      exp_q.push_back(b);
    end else begin
      for (int i = 0; i < adj[node].size(); i++) begin
        b.d = NW'(adj[node][i]); b.p = PW'(port);
        b.l = (i == adj[node].size() - 1); b.n = 1'b0;
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic check_stats();
    int e, n;
    e = 0; n = 0;
`ifdef ADJ_MAP_STATS_EN
    e = m_edges;
    for (int i = 0; i < MN; i++) if (adj[i].size() > 0) n++;
`endif
    check("stat_edge_count", 64'(stat_edge_count), 64'(e));
    check("stat_node_count", 64'(stat_node_count), 64'(n));
  endtask

  // reply_ready driver
  always @(posedge clk) begin
    #1;
    case (rr_mode)
      1:       reply_ready = 1'($urandom_range(1, 0));
      2:       begin reply_ready = pat[pat_i % 4]; pat_i++; end
      default: reply_ready = 1'b1;
    endcase
  end

  // monitor: pops the scoreboard on each accepted beat, checks stability during stalls
  logic [NW+PW+2:0] held;
  bit               stall = 0;
  always @(negedge clk) begin
    if (!rst_n) stall = 0;
    else begin
      if (stall)
        check("stall_stable", 64'({reply_valid, reply_data, reply_port, reply_last, reply_no_edges_found}), 64'(held));
      if (reply_valid && reply_ready) begin
        stall = 0;
        if (exp_q.size() == 0) check("unexpected_beat", 64'(reply_data), 64'hDEAD);
        else begin
          beat_t b;
          b = exp_q.pop_front();
          check("beat", 64'({reply_data, reply_port, reply_last, reply_no_edges_found}), 64'(b));
        end
      end else if (reply_valid) begin
        stall = 1;
        held  = {reply_valid, reply_data, reply_port, reply_last, reply_no_edges_found};
      end else stall = 0;
    end
  end

  // all tasks below start and end 1 time unit after a rising edge
  task automatic put_edge(input int s, input int d, input bit done);
    src_node = NW'(s); dst_node = NW'(d); edge_valid = 1'b1; decoding_done = done;
    if (m_edges < ME) begin adj[s].push_back(d); m_edges++; end
    else m_ovf = 1;
    @(posedge clk); #1;
    edge_valid = 1'b0; decoding_done = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) begin
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic do_query(input int port, input int node);
    bit got;
    got = 0;
    query_data[port*NW +: NW] = NW'(node);
    query_valid[port] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (query_ready != '0) begin got = 1; break; end
    end
    if (!got) begin
      check("grant_timeout", 64'(query_ready), 64'(1 << port));
      query_valid = '0;
      @(posedge clk); #1;
      return;
    end
    check("grant", 64'(query_ready), 64'(1 << port));
    push_expect(node, port);
    m_last = port;
    @(posedge clk); #1;
    query_valid[port] = 1'b0;
    @(negedge clk); check("lookup_cycle_no_valid", 64'(reply_valid), 64'd0);
    @(negedge clk); check("first_beat_latency", 64'(reply_valid), 64'd1);
    drain();
  endtask

  task automatic multi(input logic [NP-1:0] mask, input int count);
    int qn[NP];
    for (int p = 0; p < NP; p++) begin
      qn[p] = $urandom_range(MN - 1, 0);
      query_data[p*NW +: NW] = NW'(qn[p]);
    end
    query_valid = mask;
    for (int k = 0; k < count; k++) begin
      bit got;
      int g;
      got = 0;
      for (int i = 0; i < 600; i++) begin
        @(negedge clk);
        if (query_ready != '0) begin got = 1; break; end
      end
      g = next_grant(m_last, mask);
      if (!got) begin
        check("rr_grant_timeout", 64'(query_ready), 64'(1 << g));
        break;
      end
      check("rr_grant", 64'(query_ready), 64'(1 << g));
      push_expect(qn[g], g);
      m_last = g;
      @(posedge clk); #1;
      qn[g] = $urandom_range(MN - 1, 0);
      query_data[g*NW +: NW] = NW'(qn[g]);
    end
    query_valid = '0;
    drain();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_query_ready"}, 64'(query_ready), 64'd0);
    check({tag, "_reply_valid"}, 64'(reply_valid), 64'd0);
    check({tag, "_reply_data"}, 64'(reply_data), 64'd0);
    check({tag, "_reply_port"}, 64'(reply_port), 64'd0);
    check({tag, "_reply_last"}, 64'(reply_last), 64'd0);
    check({tag, "_no_edges"}, 64'(reply_no_edges_found), 64'd0);
    check({tag, "_edge_overflow"}, 64'(edge_overflow), 64'd0);
    check({tag, "_stat_edge"}, 64'(stat_edge_count), 64'd0);
    check({tag, "_stat_node"}, 64'(stat_node_count), 64'd0);
  endtask

  initial begin
    bit got;
    rst_n = 1'b0; decoding_done = 0; edge_valid = 0; src_node = '0; dst_node = '0;
    query_valid = '0; query_data = '0; reply_ready = 1'b1;
    model_reset();
    #2 check_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // queries are blocked while building
    query_valid[0] = 1'b1;
    repeat (3) begin @(negedge clk); check("build_no_grant", 64'(query_ready), 64'd0); end
    @(posedge clk); #1 query_valid = '0;

    put_edge(3, 5, 0); put_edge(7, 1, 0); put_edge(3, 9, 0); put_edge(3, 2, 0);
    for (int i = 0; i < 20; i++) begin
      int s;
      do s = $urandom_range(MN - 1, 0); while (s == 3 || s == 4);
      put_edge(s, $urandom_range(MN - 1, 0), i == 19);
    end
    @(negedge clk);
    check("no_overflow", 64'(edge_overflow), 64'd0);
    check_stats();
    @(posedge clk); #1;

    do_query(0, 3);
    do_query(1, 4);
    rr_mode = 2;
    do_query(0, 3);
    rr_mode = 1;
    for (int i = 0; i < 8; i++) do_query($urandom_range(NP - 1, 0), $urandom_range(MN - 1, 0));
    multi(3'b011, 8);
    multi(3'b111, 9);

    // overflow: more edges than the list holds
    do_reset();
    for (int i = 0; i < ME + 8; i++)
      put_edge($urandom_range(MN - 1, 0), $urandom_range(MN - 1, 0), i == ME + 7);
    @(negedge clk);
    check("overflow_set", 64'(edge_overflow), 64'(m_ovf));
    check_stats();
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) do_query($urandom_range(NP - 1, 0), $urandom_range(MN - 1, 0));
    multi(3'b111, 6);

    // reset in the middle of a reply
    do_reset();
    rr_mode = 0;
    for (int i = 0; i < 5; i++) put_edge(3, 10 + i, i == 4);
    query_data[2*NW +: NW] = NW'(3);
    query_valid[2] = 1'b1;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (query_ready != '0) begin got = 1; break; end
    end
    check("midreply_grant", 64'(query_ready), 64'(3'b100));
    if (got) push_expect(3, 2);
    @(posedge clk); #1 query_valid = '0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("midreply_reset");
    exp_q.delete();
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    query_valid[0] = 1'b1;
    repeat (4) begin @(negedge clk); check("post_reset_no_grant", 64'(query_ready), 64'd0); end
    @(posedge clk); #1 query_valid = '0;
    decoding_done = 1'b1;
    @(posedge clk); #1 decoding_done = 1'b0;
    do_query(0, 3);
    check("post_reset_no_overflow", 64'(edge_overflow), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
